// File: rtl/change_dispenser_if.sv
// Coin-dispense bundle between the vending controller (master) and change_dispenser (slave):
// request, coin channel, completion status, refill and stock readback.
interface change_dispenser_if #(
    parameter int unsigned AMT_W   = 5,
    parameter int unsigned STOCK_W = 8
);
    logic               io_req_valid;
    logic [AMT_W-1:0]   io_req_amount;
    logic               io_req_ready;
    logic               io_coin_valid;
    logic               io_coin;
    logic               io_coin_ready;
    logic               io_done;
    logic               io_short;
    logic [AMT_W-1:0]   io_remainder;
    logic               io_refill_valid;
    logic [STOCK_W-1:0] io_refill_dimes;
    logic [STOCK_W-1:0] io_refill_nicks;
    logic [STOCK_W-1:0] io_dimes;
    logic [STOCK_W-1:0] io_nicks;

    modport master (
        output io_req_valid, io_req_amount, io_coin_ready,
        output io_refill_valid, io_refill_dimes, io_refill_nicks,
        input  io_req_ready, io_coin_valid, io_coin, io_done, io_short, io_remainder,
        input  io_dimes, io_nicks
    );

    modport slave (
        input  io_req_valid, io_req_amount, io_coin_ready,
        input  io_refill_valid, io_refill_dimes, io_refill_nicks,
        output io_req_ready, io_coin_valid, io_coin, io_done, io_short, io_remainder,
        output io_dimes, io_nicks
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy dime/nickel change dispenser with finite, refillable stock.
// Define CHANGE_DISPENSER_STATS_EN to add the io_coins_out transfer counter.
module change_dispenser #(
    parameter int unsigned AMT_W      = 5,
    parameter int unsigned STOCK_W    = 8,
    parameter int unsigned INIT_DIMES = 10,
    parameter int unsigned INIT_NICKS = 10
) (
    input logic              clk,
    input logic              reset,
    change_dispenser_if.slave bus
`ifdef CHANGE_DISPENSER_STATS_EN
    ,
    output logic [15:0]      io_coins_out
`endif
);

    typedef enum logic [1:0] {StIdle, StDispense, StDone} state_e;

    state_e             state_q;
    logic [AMT_W-1:0]   rem_q;
    logic [STOCK_W-1:0] dimes_q, nicks_q;
    logic               ready_q, done_q, short_q;
    logic [AMT_W-1:0]   remainder_q;
    logic               hold_q, hold_coin_q;

    logic dime_ok, nick_ok, coin_valid, coin_sel, xfer;

    // A coin left waiting on a stalled channel is held, so a refill cannot swap it.
    always_comb begin
        dime_ok    = (rem_q >= AMT_W'(2)) && (dimes_q != '0);
        nick_ok    = (rem_q != '0) && (nicks_q != '0);
        coin_valid = (state_q == StDispense) && (hold_q || dime_ok || nick_ok);
        coin_sel   = hold_q ? hold_coin_q : !dime_ok;
        xfer       = coin_valid && bus.io_coin_ready;
    end

    function automatic logic [STOCK_W-1:0] stock_next(input logic [STOCK_W-1:0] stock,
                                                      input logic               add_en,
                                                      input logic [STOCK_W-1:0] add,
                                                      input logic               dec);
        logic [STOCK_W:0] sum;
        sum = {1'b0, stock} + (add_en ? {1'b0, add} : '0) - {{STOCK_W{1'b0}}, dec};
        return sum[STOCK_W] ? '1 : sum[STOCK_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            rem_q       <= '0;
            dimes_q     <= STOCK_W'(INIT_DIMES);
            nicks_q     <= STOCK_W'(INIT_NICKS);
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            short_q     <= 1'b0;
            remainder_q <= '0;
            hold_q      <= 1'b0;
            hold_coin_q <= 1'b0;
        end else begin
            dimes_q     <= stock_next(dimes_q, bus.io_refill_valid, bus.io_refill_dimes,
                                      xfer && !coin_sel);
            nicks_q     <= stock_next(nicks_q, bus.io_refill_valid, bus.io_refill_nicks,
                                      xfer && coin_sel);
            done_q      <= 1'b0;
            short_q     <= 1'b0;
            remainder_q <= '0;
            hold_q      <= coin_valid && !bus.io_coin_ready;
            if (coin_valid && !bus.io_coin_ready) hold_coin_q <= coin_sel;

            unique case (state_q)
                StIdle: begin
                    if (ready_q && bus.io_req_valid) begin
                        rem_q   <= bus.io_req_amount;
                        ready_q <= 1'b0;
                        state_q <= StDispense;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                StDispense: begin
                    if (xfer) begin
                        rem_q <= rem_q - (coin_sel ? AMT_W'(1) : AMT_W'(2));
                    end else if (!coin_valid) begin
                        done_q      <= 1'b1;
                        short_q     <= (rem_q != '0);
                        remainder_q <= rem_q;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef CHANGE_DISPENSER_STATS_EN
    logic [15:0] coins_q;
    always_ff @(posedge clk) begin
        if (!reset)    coins_q <= '0;
        else if (xfer) coins_q <= coins_q + 16'd1;
    end
    assign io_coins_out = coins_q;
`endif

    assign bus.io_req_ready  = ready_q;
    assign bus.io_coin_valid = coin_valid;
    assign bus.io_coin       = coin_valid ? coin_sel : 1'b0;
    assign bus.io_done       = done_q;
    assign bus.io_short      = short_q;
    assign bus.io_remainder  = remainder_q;
    assign bus.io_dimes      = dimes_q;
    assign bus.io_nicks      = nicks_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus a randomized run against
// a coin-count model of the greedy dispenser.
module tb_change_dispenser;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    change_dispenser_if bus ();
`ifdef CHANGE_DISPENSER_STATS_EN
    logic [15:0] coins_out;
`endif

    change_dispenser dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef CHANGE_DISPENSER_STATS_EN
        ,
        .io_coins_out (coins_out)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.io_req_valid    = 1'b0;
        bus.io_req_amount   = '0;
        bus.io_coin_ready   = 1'b0;
        bus.io_refill_valid = 1'b0;
        bus.io_refill_dimes = '0;
        bus.io_refill_nicks = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Waits (bounded) for ready, presents one request; returns in the first cycle after accept.
    task automatic accept(input int amt);
        for (int i = 0; i < 50 && bus.io_req_ready !== 1'b1; i++) tick();
        if (bus.io_req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got ready=%0b want 1", bus.io_req_ready);
        end
        bus.io_req_valid  = 1'b1;
        bus.io_req_amount = 5'(amt);
        tick();
        bus.io_req_valid  = 1'b0;
        #1;
    endtask

    task automatic run_silent(input int amt);
        bus.io_coin_ready = 1'b1;
        accept(amt);
        for (int i = 0; i < 100 && bus.io_done !== 1'b1; i++) tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        tick();
        tick();
        checks++; if (bus.io_coin_valid !== 1'b0) begin errors++;
            $display("FAIL rst_coin_valid got %0b want 0", bus.io_coin_valid); end
        checks++; if (bus.io_done !== 1'b0 || bus.io_short !== 1'b0) begin errors++;
            $display("FAIL rst_done_short got %0b%0b want 00", bus.io_done, bus.io_short); end
        checks++; if (bus.io_remainder !== 5'd0) begin errors++;
            $display("FAIL rst_remainder got %0d want 0", bus.io_remainder); end
        checks++; if (bus.io_dimes !== 8'd10 || bus.io_nicks !== 8'd10) begin errors++;
            $display("FAIL rst_stock got %0d/%0d want 10/10", bus.io_dimes, bus.io_nicks); end
        reset = 1'b1;
        tick();
        checks++; if (bus.io_req_ready !== 1'b1) begin errors++;
            $display("FAIL rst_ready got %0b want 1", bus.io_req_ready); end
    endtask

    task automatic test_basic();
        do_reset();
        bus.io_coin_ready = 1'b1;
        accept(4);
        checks++; if (bus.io_coin_valid !== 1'b1 || bus.io_coin !== 1'b0) begin errors++;
            $display("FAIL amt4_c0 got v%0b c%0b want v1 c0", bus.io_coin_valid, bus.io_coin); end
        tick();
        checks++; if (bus.io_coin_valid !== 1'b1 || bus.io_coin !== 1'b0) begin errors++;
            $display("FAIL amt4_c1 got v%0b c%0b want v1 c0", bus.io_coin_valid, bus.io_coin); end
        tick();
        checks++; if (bus.io_coin_valid !== 1'b0) begin errors++;
            $display("FAIL amt4_end got v%0b want v0", bus.io_coin_valid); end
        tick();
        checks++; if (bus.io_done !== 1'b1 || bus.io_short !== 1'b0 || bus.io_dimes !== 8'd8)
            begin errors++; $display("FAIL amt4_done got d%0b s%0b dimes %0d want d1 s0 dimes 8",
                bus.io_done, bus.io_short, bus.io_dimes); end

        do_reset();
        bus.io_coin_ready = 1'b1;
        accept(3);
        checks++; if (bus.io_coin !== 1'b0) begin errors++;
            $display("FAIL amt3_c0 got %0b want 0", bus.io_coin); end
        tick();
        checks++; if (bus.io_coin_valid !== 1'b1 || bus.io_coin !== 1'b1) begin errors++;
            $display("FAIL amt3_c1 got v%0b c%0b want v1 c1", bus.io_coin_valid, bus.io_coin); end
        tick();
        tick();
        checks++; if (bus.io_done !== 1'b1 || bus.io_short !== 1'b0 || bus.io_dimes !== 8'd9 ||
                      bus.io_nicks !== 8'd9) begin errors++;
            $display("FAIL amt3_done got d%0b s%0b %0d/%0d want d1 s0 9/9", bus.io_done,
                bus.io_short, bus.io_dimes, bus.io_nicks); end

        do_reset();
        run_silent(20);
        run_silent(9);
        checks++; if (bus.io_dimes !== 8'd0 || bus.io_nicks !== 8'd1) begin errors++;
            $display("FAIL drain_stock got %0d/%0d want 0/1", bus.io_dimes, bus.io_nicks); end
        bus.io_coin_ready = 1'b1;
        accept(4);
        checks++; if (bus.io_coin_valid !== 1'b1 || bus.io_coin !== 1'b1) begin errors++;
            $display("FAIL short_coin got v%0b c%0b want v1 c1", bus.io_coin_valid, bus.io_coin); end
        tick();
        tick();
        checks++; if (bus.io_done !== 1'b1 || bus.io_short !== 1'b1 || bus.io_remainder !== 5'd3)
            begin errors++; $display("FAIL short_done got d%0b s%0b r%0d want d1 s1 r3",
                bus.io_done, bus.io_short, bus.io_remainder); end
    endtask

    task automatic test_stall_refill();
        do_reset();
        run_silent(20);
        bus.io_coin_ready = 1'b0;
        accept(4);
        for (int k = 0; k < 5; k++) begin
            bus.io_refill_valid = 1'b1;
            bus.io_refill_dimes = 8'd5;
            #1;
            checks++; if (bus.io_coin_valid !== 1'b1 || bus.io_coin !== 1'b1 ||
                          bus.io_dimes !== 8'(5 * k)) begin errors++;
                $display("FAIL stall_%0d got v%0b c%0b dimes %0d want v1 c1 dimes %0d", k,
                    bus.io_coin_valid, bus.io_coin, bus.io_dimes, 5 * k); end
            tick();
        end
        bus.io_refill_valid = 1'b0;
        bus.io_coin_ready   = 1'b1;
        #1;
        checks++; if (bus.io_coin !== 1'b1 || bus.io_dimes !== 8'd25) begin errors++;
            $display("FAIL stall_frozen got c%0b dimes %0d want c1 dimes 25", bus.io_coin,
                bus.io_dimes); end
        tick();
        checks++; if (bus.io_coin !== 1'b0 || bus.io_nicks !== 8'd9) begin errors++;
            $display("FAIL stall_next got c%0b nicks %0d want c0 nicks 9", bus.io_coin,
                bus.io_nicks); end
        tick();
        tick();
        tick();
        checks++; if (bus.io_done !== 1'b1 || bus.io_short !== 1'b0 || bus.io_nicks !== 8'd8 ||
                      bus.io_dimes !== 8'd24) begin errors++;
            $display("FAIL stall_done got d%0b s%0b %0d/%0d want d1 s0 24/8", bus.io_done,
                bus.io_short, bus.io_dimes, bus.io_nicks); end
        tick();
        bus.io_refill_valid = 1'b1;
        bus.io_refill_dimes = 8'd250;
        tick();
        bus.io_refill_valid = 1'b0;
        #1;
        checks++; if (bus.io_dimes !== 8'd255 || bus.io_nicks !== 8'd8) begin errors++;
            $display("FAIL saturate got %0d/%0d want 255/8", bus.io_dimes, bus.io_nicks); end
        bus.io_refill_valid = 1'b1;
        bus.io_refill_dimes = 8'd1;
        bus.io_coin_ready   = 1'b1;
        accept(2);
        tick();
        bus.io_refill_valid = 1'b0;
        #1;
        checks++; if (bus.io_dimes !== 8'd255) begin errors++;
            $display("FAIL sat_net got %0d want 255", bus.io_dimes); end
        tick();
        tick();
        run_silent(2);
        checks++; if (bus.io_dimes !== 8'd254) begin errors++;
            $display("FAIL sat_dec got %0d want 254", bus.io_dimes); end
    endtask

    task automatic test_zero();
        do_reset();
        bus.io_coin_ready = 1'b1;
        accept(0);
        checks++; if (bus.io_coin_valid !== 1'b0 || bus.io_done !== 1'b0) begin errors++;
            $display("FAIL zero_first got v%0b d%0b want v0 d0", bus.io_coin_valid, bus.io_done); end
        tick();
        checks++; if (bus.io_done !== 1'b1 || bus.io_short !== 1'b0 || bus.io_remainder !== 5'd0)
            begin errors++; $display("FAIL zero_done got d%0b s%0b r%0d want d1 s0 r0",
                bus.io_done, bus.io_short, bus.io_remainder); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.io_coin_ready = 1'b1;
        accept(6);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        checks++; if (bus.io_done !== 1'b0 || bus.io_coin_valid !== 1'b0 ||
                      bus.io_dimes !== 8'd10 || bus.io_nicks !== 8'd10) begin errors++;
            $display("FAIL mid_rst got d%0b v%0b %0d/%0d want d0 v0 10/10", bus.io_done,
                bus.io_coin_valid, bus.io_dimes, bus.io_nicks); end
        tick();
        checks++; if (bus.io_req_ready !== 1'b1 || bus.io_done !== 1'b0) begin errors++;
            $display("FAIL mid_rst_ready got r%0b d%0b want r1 d0", bus.io_req_ready,
                bus.io_done); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.io_coin_ready = 1'b1;
        accept(10);
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.io_coin_valid !== 1'b1 || bus.io_coin !== 1'b0 ||
                          bus.io_dimes !== 8'(10 - i)) begin errors++;
                $display("FAIL b2b_%0d got v%0b c%0b dimes %0d want v1 c0 dimes %0d", i,
                    bus.io_coin_valid, bus.io_coin, bus.io_dimes, 10 - i); end
            tick();
        end
        checks++; if (bus.io_coin_valid !== 1'b0 || bus.io_dimes !== 8'd5) begin errors++;
            $display("FAIL b2b_end got v%0b dimes %0d want v0 dimes 5", bus.io_coin_valid,
                bus.io_dimes); end
        tick();
        tick();
    endtask

    task automatic test_random();
        int  m_d, m_n, rem, amt, rd, rn;
        bit  held, held_coin, ev, ec, cr, rv;
        do_reset();
        m_d = 10;
        m_n = 10;
        for (int r = 0; r < 40; r++) begin
            amt = $urandom_range(0, 31);
            idle_inputs();
            accept(amt);
            rem  = amt;
            held = 1'b0;
            for (int c = 0; c < 200; c++) begin
                cr = ($urandom_range(0, 3) != 0);
                rv = ($urandom_range(0, 3) == 0);
                rd = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 3);
                rn = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 3);
                bus.io_coin_ready   = cr;
                bus.io_refill_valid = rv;
                bus.io_refill_dimes = 8'(rd);
                bus.io_refill_nicks = 8'(rn);
                #1;
                if (held)                      begin ev = 1; ec = held_coin; end
                else if (rem >= 2 && m_d > 0)  begin ev = 1; ec = 0; end
                else if (rem >= 1 && m_n > 0)  begin ev = 1; ec = 1; end
                else                           begin ev = 0; ec = 0; end
                checks++; if (bus.io_coin_valid !== ev || (ev && bus.io_coin !== ec)) begin
                    errors++; $display("FAIL rnd_coin req %0d got v%0b c%0b want v%0b c%0b", r,
                        bus.io_coin_valid, bus.io_coin, ev, ec); end
                checks++; if (bus.io_dimes !== 8'(m_d) || bus.io_nicks !== 8'(m_n)) begin
                    errors++; $display("FAIL rnd_stock req %0d got %0d/%0d want %0d/%0d", r,
                        bus.io_dimes, bus.io_nicks, m_d, m_n); end
                m_d = m_d + (rv ? rd : 0) - ((ev && cr && !ec) ? 1 : 0);
                m_n = m_n + (rv ? rn : 0) - ((ev && cr && ec) ? 1 : 0);
                if (m_d > 255) m_d = 255;
                if (m_n > 255) m_n = 255;
                if (ev && cr) rem = rem - (ec ? 1 : 2);
                held      = ev && !cr;
                held_coin = ec;
                tick();
                if (!ev) break;
            end
            idle_inputs();
            #1;
            checks++; if (bus.io_done !== 1'b1 || bus.io_short !== (rem != 0) ||
                          bus.io_remainder !== 5'(rem)) begin errors++;
                $display("FAIL rnd_done req %0d got d%0b s%0b r%0d want d1 s%0b r%0d", r,
                    bus.io_done, bus.io_short, bus.io_remainder, rem != 0, rem); end
            tick();
        end
    endtask

`ifdef CHANGE_DISPENSER_STATS_EN
    task automatic test_stats();
        do_reset();
        checks++; if (coins_out !== 16'd0) begin errors++;
            $display("FAIL stats_rst got %0d want 0", coins_out); end
        for (int i = 0; i < 3; i++) run_silent(4);
        checks++; if (coins_out !== 16'd6) begin errors++;
            $display("FAIL stats_count got %0d want 6", coins_out); end
    endtask
`endif

    initial begin
        idle_inputs();
        test_reset();
        test_basic();
        test_stall_refill();
        test_zero();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef CHANGE_DISPENSER_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
